iiitb_mem_arbiter: RTL and testbench



---
 rtl/iiitb_rv32i_pkg.sv | 14 +
 rtl/iiitb_mem_arbiter_if.sv | 53 +++++
 rtl/iiitb_starve_ctr.sv | 37 +++
 rtl/iiitb_mem_arbiter.sv | 118 +++++++++++
 tb/tb_iiitb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/iiitb_rv32i_pkg.sv
// Shared types and constants for the rv32i core's memory-side blocks.
package iiitb_rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // Which requester owns the read data returning in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_D_WR = 2'd3
  } own_t;

endpackage

// File: rtl/iiitb_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
interface iiitb_mem_arbiter_if
  import iiitb_rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = XLEN,
  parameter int unsigned DATA_W = XLEN
);

  // Fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Pipeline + memory view
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/iiitb_starve_ctr.sv
// Saturating count of consecutive load/store grants taken while fetch waits.
module iiitb_starve_ctr #(
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic max
);

  localparam int unsigned CNT_W = $clog2(MAX_D_RUN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(0);
    end else if (inc && (cnt_q != CNT_W'(MAX_D_RUN))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max = (cnt_q == CNT_W'(MAX_D_RUN));

endmodule

// File: rtl/iiitb_mem_arbiter.sv
// Single-port memory arbiter sharing one memory between fetch and load/store.
// Load/store has priority; fetch is guaranteed a slot after MAX_D_RUN
// back-to-back load/store grants. Reads return one cycle after the grant.
module iiitb_mem_arbiter
  import iiitb_rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W    = XLEN,
  parameter int unsigned DATA_W    = XLEN,
  parameter int unsigned MAX_D_RUN = 4
) (
  input logic                clk,
  input logic                rst,
  iiitb_mem_arbiter_if.slave bus
);

  logic if_eff;
  logic d_win;
  logic if_win;
  logic run_max;
  logic run_inc;
  logic run_clr;
  own_t own_q, own_d;

  // Grant selection; a flushed fetch is treated as not requesting.
  always_comb begin
    d_win  = 1'b0;
    if_win = 1'b0;
    if_eff = bus.if_req & ~bus.if_flush;
    if (!rst) begin
      if (bus.d_req && !(if_eff && run_max)) begin
        d_win = 1'b1;
      end else if (if_eff) begin
        if_win = 1'b1;
      end
    end
  end

  assign bus.if_gnt = if_win;
  assign bus.d_gnt  = d_win;

  // Winner drives the memory port; idle port is driven to zero.
  always_comb begin
    bus.mem_en    = d_win | if_win;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_wdata = DATA_W'(0);
    if (d_win) begin
      bus.mem_we   = bus.d_we;
      bus.mem_addr = bus.d_addr;
      if (bus.d_we) begin
        bus.mem_wdata = bus.d_wdata;
      end
    end else if (if_win) begin
      bus.mem_addr = bus.if_addr;
    end
  end

  // Run of load/store grants only matters while fetch is waiting.
  assign run_inc = d_win & bus.if_req;
  assign run_clr = if_win | ~bus.if_req;

  iiitb_starve_ctr #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (run_inc),
    .clr (run_clr),
    .max (run_max)
  );

  // Owner of next cycle's response, taken from this cycle's grant.
  always_comb begin
    own_d = OWN_NONE;
    if (d_win) begin
      own_d = bus.d_we ? OWN_D_WR : OWN_D;
    end else if (if_win) begin
      own_d = OWN_IF;
    end
  end

  // Owner register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Response demux; a flush in the response cycle drops a fetch response.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = DATA_W'(0);
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = DATA_W'(0);
    if (!rst) begin
      case (own_q)
        OWN_IF: begin
          if (!bus.if_flush) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end
        end
        OWN_D: begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.mem_rdata;
        end
        OWN_D_WR: begin
          bus.d_rvalid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_mem_arbiter.sv
// Bench for iiitb_mem_arbiter: directed table, contention/reset sequences,
// then constrained-random traffic checked against a rule-level model.
module tb_iiitb_mem_arbiter;
  import iiitb_rv32i_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXR = 4;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iiitb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  iiitb_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_D_RUN (MAXR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory behind the arbiter: 16 words, indexed by the low address bits.
  logic [31:0] tb_mem [16] = '{
    32'h00222000, 32'h04432800, 32'h10E60001, 32'h00001111,
    32'hAAAA0004, 32'h55550005, 32'h66660006, 32'h77770007,
    32'h88880008, 32'h99990009, 32'hAAAA000A, 32'hBBBB000B,
    32'hCCCC000C, 32'hDDDD000D, 32'hEEEE000E, 32'hFFFF000F};

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr[3:0]];
    end
  end

  // Reference model state: its own copy of memory, the owner of the pending
  // response (0 none, 1 fetch, 2 load, 3 store) and the load/store streak.
  logic [31:0] m_mem [16] = '{
    32'h00222000, 32'h04432800, 32'h10E60001, 32'h00001111,
    32'hAAAA0004, 32'h55550005, 32'h66660006, 32'h77770007,
    32'h88880008, 32'h99990009, 32'hAAAA000A, 32'hBBBB000B,
    32'hCCCC000C, 32'hDDDD000D, 32'hEEEE000E, 32'hFFFF000F};
  int unsigned m_own  = 0;
  int unsigned m_run  = 0;
  logic [31:0] m_resp = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  logic        o_if_gnt, o_d_gnt, o_mem_en, o_mem_we, o_if_rv, o_d_rv;
  logic [31:0] o_if_rd, o_d_rd;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, check against the model mid-cycle, then advance.
  task automatic apply(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd);
    logic        ife, eg_d, eg_if, e_irv, e_drv;
    logic [31:0] e_addr;
    logic [3:0]  gi;
    rst = r;
    bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    #4;
    o_if_gnt = bus.if_gnt;   o_d_gnt = bus.d_gnt;
    o_mem_en = bus.mem_en;   o_mem_we = bus.mem_we;
    o_if_rv  = bus.if_rvalid; o_d_rv = bus.d_rvalid;
    o_if_rd  = bus.if_rdata;  o_d_rd = bus.d_rdata;

    ife    = ir && !fl;
    eg_d   = !r && dr && !(ife && (m_run == MAXR));
    eg_if  = !r && !eg_d && ife;
    e_irv  = !r && (m_own == 1) && !fl;
    e_drv  = !r && ((m_own == 2) || (m_own == 3));
    e_addr = eg_d ? da : (eg_if ? ia : 32'h0);

    chk1("m_if_gnt", o_if_gnt, eg_if);
    chk1("m_d_gnt", o_d_gnt, eg_d);
    chk1("m_mem_en", o_mem_en, eg_d || eg_if);
    chk1("m_mem_we", o_mem_we, eg_d && dw);
    chk32("m_mem_addr", bus.mem_addr, e_addr);
    if (eg_d && dw)      chk32("m_mem_wdata", bus.mem_wdata, dd);
    else if (!eg_if && !eg_d) chk32("m_mem_wdata_idle", bus.mem_wdata, 32'h0);
    chk1("m_if_rvalid", o_if_rv, e_irv);
    chk1("m_d_rvalid", o_d_rv, e_drv);
    if (e_irv || r) chk32("m_if_rdata", o_if_rd, e_irv ? m_resp : 32'h0);
    if (e_drv || r) chk32("m_d_rdata", o_d_rd, (e_drv && m_own == 2) ? m_resp : 32'h0);

    @(posedge clk);
    if (r) begin
      m_own = 0;
      m_run = 0;
    end else begin
      gi = eg_d ? da[3:0] : ia[3:0];
      if (eg_d && dw) begin
        m_mem[gi] = dd;
        m_own = 3;
      end else if (eg_d || eg_if) begin
        m_resp = m_mem[gi];
        m_own  = eg_d ? 2 : 1;
      end else begin
        m_own = 0;
      end
      if (eg_if || !ir)                  m_run = 0;
      else if (eg_d && (m_run < MAXR))   m_run = m_run + 1;
    end
    #1;
  endtask

  typedef struct {
    logic r, ir; logic [31:0] ia; logic fl, dr, dw; logic [31:0] da, dd;
    logic e_ig, e_dg, e_men, e_mwe, e_irv; logic [31:0] e_ird;
    logic e_drv; logic [31:0] e_drd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, ir, fl, dr, dw, hold_if, hold_d, exp_ig;
    logic [31:0] ia, da, dd;

    //          r  ir ia      fl dr dw da     dd            ig dg en we irv ird            drv drd
    tbl[0]  = '{Y, N, 32'd0, N, N, N, 32'd0, 32'h0,        N, N, N, N, N, 32'h0,        N, 32'h0};
    tbl[1]  = '{Y, Y, 32'd0, N, Y, N, 32'd3, 32'h0,        N, N, N, N, N, 32'h0,        N, 32'h0};
    tbl[2]  = '{N, Y, 32'd0, N, N, N, 32'd0, 32'h0,        Y, N, Y, N, N, 32'h0,        N, 32'h0};
    tbl[3]  = '{N, Y, 32'd1, N, N, N, 32'd0, 32'h0,        Y, N, Y, N, Y, 32'h00222000, N, 32'h0};
    tbl[4]  = '{N, Y, 32'd2, N, N, N, 32'd0, 32'h0,        Y, N, Y, N, Y, 32'h04432800, N, 32'h0};
    tbl[5]  = '{N, N, 32'd0, N, N, N, 32'd0, 32'h0,        N, N, N, N, Y, 32'h10E60001, N, 32'h0};
    tbl[6]  = '{N, N, 32'd0, N, Y, Y, 32'd3, 32'hDEADBEEF, N, Y, Y, Y, N, 32'h0,        N, 32'h0};
    tbl[7]  = '{N, N, 32'd0, N, Y, N, 32'd3, 32'h0,        N, Y, Y, N, N, 32'h0,        Y, 32'h0};
    tbl[8]  = '{N, N, 32'd0, N, N, N, 32'd0, 32'h0,        N, N, N, N, N, 32'h0,        Y, 32'hDEADBEEF};
    tbl[9]  = '{N, Y, 32'd4, N, N, N, 32'd0, 32'h0,        Y, N, Y, N, N, 32'h0,        N, 32'h0};
    tbl[10] = '{N, Y, 32'd5, Y, N, N, 32'd0, 32'h0,        N, N, N, N, N, 32'h0,        N, 32'h0};
    tbl[11] = '{N, Y, 32'd5, N, N, N, 32'd0, 32'h0,        Y, N, Y, N, N, 32'h0,        N, 32'h0};
    tbl[12] = '{N, N, 32'd0, N, N, N, 32'd0, 32'h0,        N, N, N, N, Y, 32'h55550005, N, 32'h0};
    tbl[13] = '{N, Y, 32'd6, Y, Y, N, 32'd0, 32'h0,        N, Y, Y, N, N, 32'h0,        N, 32'h0};
    tbl[14] = '{N, N, 32'd0, N, N, N, 32'd0, 32'h0,        N, N, N, N, N, 32'h0,        Y, 32'h00222000};

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    @(posedge clk);
    #1;

    // Directed table: fetch stream, store/load, flush cases.
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].fl, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      chk1($sformatf("row%0d_if_gnt", i), o_if_gnt, tbl[i].e_ig);
      chk1($sformatf("row%0d_d_gnt", i), o_d_gnt, tbl[i].e_dg);
      chk1($sformatf("row%0d_mem_en", i), o_mem_en, tbl[i].e_men);
      chk1($sformatf("row%0d_mem_we", i), o_mem_we, tbl[i].e_mwe);
      chk1($sformatf("row%0d_if_rvalid", i), o_if_rv, tbl[i].e_irv);
      chk1($sformatf("row%0d_d_rvalid", i), o_d_rv, tbl[i].e_drv);
      if (tbl[i].e_irv || tbl[i].r) chk32($sformatf("row%0d_if_rdata", i), o_if_rd, tbl[i].e_ird);
      if (tbl[i].e_drv || tbl[i].r) chk32($sformatf("row%0d_d_rdata", i), o_d_rd, tbl[i].e_drd);
    end

    // Contention: both held for 10 cycles -> D,D,D,D,IF,D,D,D,D,IF.
    for (int i = 0; i < 10; i++) begin
      apply(N, Y, 32'd8, N, Y, N, 32'd7, 32'h0);
      exp_ig = ((i % 5) == 4);
      chk1($sformatf("contend%0d_if_gnt", i), o_if_gnt, exp_ig);
      chk1($sformatf("contend%0d_d_gnt", i), o_d_gnt, !exp_ig);
    end
    apply(N, N, 32'd0, N, N, N, 32'd0, 32'h0);
    chk1("contend_tail_if_rvalid", o_if_rv, Y);
    chk32("contend_tail_if_rdata", o_if_rd, 32'h88880008);

    // Reset pulse in the cycle after a load grant.
    apply(N, N, 32'd0, N, Y, N, 32'd2, 32'h0);
    chk1("rstload_d_gnt", o_d_gnt, Y);
    apply(Y, Y, 32'd1, N, Y, N, 32'd2, 32'h0);
    chk1("rstload_d_rvalid_in_rst", o_d_rv, N);
    chk1("rstload_d_gnt_in_rst", o_d_gnt, N);
    chk1("rstload_if_gnt_in_rst", o_if_gnt, N);
    chk1("rstload_mem_en_in_rst", o_mem_en, N);
    chk32("rstload_d_rdata_in_rst", o_d_rd, 32'h0);
    apply(N, N, 32'd0, N, N, N, 32'd0, 32'h0);
    chk1("rstload_d_rvalid_after", o_d_rv, N);
    chk1("rstload_if_rvalid_after", o_if_rv, N);
    apply(N, N, 32'd0, N, Y, N, 32'd2, 32'h0);
    chk1("rstload_regrant", o_d_gnt, Y);
    apply(N, N, 32'd0, N, N, N, 32'd0, 32'h0);
    chk1("rstload_resp_valid", o_d_rv, Y);
    chk32("rstload_resp_data", o_d_rd, 32'h10E60001);

    // Random traffic; requesters hold their request until granted.
    hold_if = 1'b0; hold_d = 1'b0;
    ir = 1'b0; ia = 32'h0; dr = 1'b0; dw = 1'b0; da = 32'h0; dd = 32'h0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 49) == 0);
      if (!hold_if) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = $urandom;
      end
      fl = ($urandom_range(0, 7) == 0);
      if (!hold_d) begin
        dr = ($urandom_range(0, 3) != 0);
        dw = ($urandom_range(0, 1) == 1);
        da = $urandom;
        dd = $urandom;
      end
      apply(r, ir, ia, fl, dr, dw, da, dd);
      hold_if = ir && !o_if_gnt && !fl && !r;
      hold_d  = dr && !o_d_gnt && !r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
